alu_core: RTL and testbench



---
 rtl/alu_core.sv | 133 +++++++++++++
 tb/tb_alu_core.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Integer ALU with registered flag copy; ALU_SHIFT_EN adds SLL/SRL/SRA on codes 1000-1010.
// Result/flags are zero-latency combinational; o_flags updates one edge after i_flag_we, no backpressure.
module alu_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [3:0]            i_aluctr,
    input  logic                  i_flag_we,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_cf,
    output logic                  o_zf,
    output logic                  o_of,
    output logic                  o_sf,
    output logic [3:0]            o_flags
);

    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLTU = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010
    } aluop_t;

    typedef struct packed {
        logic of;
        logic sf;
        logic zf;
        logic cf;
    } flags_t;

    logic                  w_sub;
    logic [DATA_WIDTH-1:0] w_b_op;
    logic [DATA_WIDTH:0]   w_sum_ext;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_cout;
    logic                  w_add_of;
    logic                  w_slt;
    logic                  w_sltu;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_cf;
    logic                  w_of;
    flags_t                w_flags;
    flags_t                r_flags;

    // One shared adder: subtraction is a + ~b + 1, so carry-out is the inverse of borrow.
    assign w_sub     = (i_aluctr == OP_SUB);
    assign w_b_op    = w_sub ? ~i_b : i_b;
    assign w_sum_ext = {1'b0, i_a} + {1'b0, w_b_op} + {{DATA_WIDTH{1'b0}}, w_sub};
    assign w_sum     = w_sum_ext[DATA_WIDTH-1:0];
    assign w_cout    = w_sum_ext[DATA_WIDTH];
    assign w_add_of  = (i_a[MSB] == w_b_op[MSB]) && (w_sum[MSB] != i_a[MSB]);

    assign w_slt  = ($signed(i_a) < $signed(i_b));
    assign w_sltu = (i_a < i_b);

`ifdef ALU_SHIFT_EN
    localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH-1:0] w_sll;
    logic [DATA_WIDTH-1:0] w_srl;
    logic [DATA_WIDTH-1:0] w_sra;

    assign w_shamt = i_b[SHW-1:0];
    assign w_sll   = i_a << w_shamt;
    assign w_srl   = i_a >> w_shamt;
    assign w_sra   = $unsigned($signed(i_a) >>> w_shamt);
`endif

    always_comb begin
        w_result = '0;
        w_cf     = 1'b0;
        w_of     = 1'b0;
        case (i_aluctr)
            OP_ADD: begin
                w_result = w_sum;
                w_cf     = w_cout;
                w_of     = w_add_of;
            end
            OP_SUB: begin
                w_result = w_sum;
                w_cf     = ~w_cout;
                w_of     = w_add_of;
            end
            OP_AND:  w_result = i_a & i_b;
            OP_OR:   w_result = i_a | i_b;
            OP_XOR:  w_result = i_a ^ i_b;
            OP_SLT:  w_result = {{(DATA_WIDTH-1){1'b0}}, w_slt};
            OP_SLTU: w_result = {{(DATA_WIDTH-1){1'b0}}, w_sltu};
            OP_NOR:  w_result = ~(i_a | i_b);
`ifdef ALU_SHIFT_EN
            OP_SLL:  w_result = w_sll;
            OP_SRL:  w_result = w_srl;
            OP_SRA:  w_result = w_sra;
`endif
            default: w_result = '0;
        endcase
    end

    assign w_flags.of = w_of;
    assign w_flags.sf = w_result[MSB];
    assign w_flags.zf = (w_result == '0);
    assign w_flags.cf = w_cf;

    assign o_result = w_result;
    assign o_cf     = w_flags.cf;
    assign o_zf     = w_flags.zf;
    assign o_of     = w_flags.of;
    assign o_sf     = w_flags.sf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flags <= '0;
        end else if (i_flag_we) begin
            r_flags <= w_flags;
        end
    end

    assign o_flags = r_flags;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: combinational result/flags and the flag register.
module tb_alu_core;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flag_we;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] result;
    logic         cf, zf, of, sf;
    logic [3:0]   flags;

    int n_chk  = 0;
    int n_pass = 0;

    alu_core #(.DATA_WIDTH(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_a       (a),
        .i_b       (b),
        .i_aluctr  (op),
        .i_flag_we (flag_we),
        .o_result  (result),
        .o_cf      (cf),
        .o_zf      (zf),
        .o_of      (of),
        .o_sf      (sf),
        .o_flags   (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Apply one vector and compare result plus {of,sf,zf,cf}.
    task automatic vec(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp_res, input logic [3:0] exp_fl);
        op = o; a = x; b = y;
        #1;
        check({tag, ".res"}, 64'(result), 64'(exp_res));
        check({tag, ".flg"}, 64'({of, sf, zf, cf}), 64'(exp_fl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flag_we = 1'b0; op = 4'd0; a = '0; b = '0;
        @(negedge clk);
        vec("add_in_rst", 4'b0000, 32'h10, 32'h20, 32'h30, 4'b0000);
        @(posedge clk); #1;
        check("rst_flags", 64'(flags), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        vec("add_basic",  4'b0000, 32'h10,       32'h20,       32'h30,       4'b0000);
        vec("add_carry",  4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0011);
        vec("add_ovf",    4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1100);
        vec("sub_basic",  4'b0001, 32'h30,       32'h10,       32'h20,       4'b0000);
        vec("sub_borrow", 4'b0001, 32'h10,       32'h30,       32'hFFFFFFE0, 4'b0101);
        vec("sub_ovf",    4'b0001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b1000);
        vec("sub_equal",  4'b0001, 32'h5,        32'h5,        32'h0,        4'b0010);
        vec("and",        4'b0010, 32'h0F,       32'hF0,       32'h0,        4'b0010);
        vec("or",         4'b0011, 32'h0F,       32'hF0,       32'hFF,       4'b0000);
        vec("xor",        4'b0100, 32'h0F,       32'hF0,       32'hFF,       4'b0000);
        vec("nor",        4'b0111, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0100);
        vec("slt_pos",    4'b0101, 32'h10,       32'h20,       32'h1,        4'b0000);
        vec("slt_neg",    4'b0101, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000);
        vec("slt_false",  4'b0101, 32'h20,       32'h10,       32'h0,        4'b0010);
        vec("sltu",       4'b0110, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0010);
        vec("sltu_true",  4'b0110, 32'h1,        32'hFFFFFFFF, 32'h1,        4'b0000);
        vec("op_undef",   4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        4'b0010);
`ifdef ALU_SHIFT_EN
        vec("sll31",      4'b1000, 32'h1,        32'd31,       32'h80000000, 4'b0100);
        vec("sra4",       4'b1010, 32'h80000000, 32'd4,        32'hF8000000, 4'b0100);
        vec("srl4",       4'b1001, 32'h80000000, 32'd4,        32'h08000000, 4'b0000);
        vec("sll33",      4'b1000, 32'h1,        32'd33,       32'h2,        4'b0000);
`else
        vec("sll_off",    4'b1000, 32'h1,        32'd31,       32'h0,        4'b0010);
        vec("sra_off",    4'b1010, 32'h80000000, 32'd4,        32'h0,        4'b0010);
`endif

        // Flag register: capture, hold, back-to-back capture, reset priority.
        @(negedge clk);
        op = 4'b0000; a = 32'hFFFFFFFF; b = 32'h1; flag_we = 1'b1;
        @(posedge clk); #1;
        check("we_carry", 64'(flags), 64'b0011);
        @(negedge clk);
        flag_we = 1'b0; a = 32'h7FFFFFFF; b = 32'h1;
        @(posedge clk); #1;
        check("hold", 64'(flags), 64'b0011);
        @(negedge clk);
        flag_we = 1'b1;
        @(posedge clk); #1;
        check("b2b_1", 64'(flags), 64'b1100);
        op = 4'b0001; a = 32'h10; b = 32'h30;
        @(posedge clk); #1;
        check("b2b_2", 64'(flags), 64'b0101);
        @(negedge clk);
        rst = 1'b1; op = 4'b0000; a = 32'hFFFFFFFF; b = 32'h1;
        @(posedge clk); #1;
        check("rst_and_we", 64'(flags), 64'h0);
        @(negedge clk);
        rst = 1'b0; flag_we = 1'b0;
        @(posedge clk); #1;
        check("after_rst_hold", 64'(flags), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
